multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore-style control FSM for a multicycle MIPS-subset datapath.
// Latency (mem_ready=1): lw 5, sw 4, R-type 4, I-type ALU 4, beq 3, j 3 cycles.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; no other stalls.
//
// Optional feature: define MULTICYCLE_JUMP_EN to decode opcode 0x02 (j) into the
// JUMP state; without it 0x02 is reported as illegal and JUMP is unreachable.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   opcode[5:0]         - instruction[31:26], stable from DECODE to completion
//   mem_ready           - memory access completes this cycle
//   pc_write .. alu_op  - datapath controls, decoded from state
//   state[3:0]          - current state encoding (debug)
//   illegal             - one-cycle pulse in DECODE on an unsupported opcode
//   retired[15:0]       - count of completed instructions (wraps)
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic [3:0]  alu_op,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_e      state_q, state_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;

  // Raw (ungated) decode of the current state; reset gating applied below.
  logic        pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
  logic [1:0]  asb, pcs;
  logic [3:0]  aop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcw     = 1'b0;
    pcwc    = 1'b0;
    iod     = 1'b0;
    mrd     = 1'b0;
    mwr     = 1'b0;
    irw     = 1'b0;
    m2r     = 1'b0;
    rdst    = 1'b0;
    rw      = 1'b0;
    asa     = 1'b0;
    ill     = 1'b0;
    asb     = 2'b00;
    pcs     = 2'b00;
    aop     = 4'd0;
    retire  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mrd = 1'b1;
        asb = 2'b01;
        // PC+4 and IR load only on the cycle the fetch actually completes.
        pcw = mem_ready;
        irw = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        asb = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                       state_d = S_MEMADR;
          OP_RTYPE:                           state_d = S_RTEXEC;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_LUI:                     state_d = S_IEXEC;
          OP_BEQ:                             state_d = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:                               state_d = S_JUMP;
`endif
          default: begin
            state_d = S_FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        asa     = 1'b1;
        asb     = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mrd = 1'b1;
        iod = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rw      = 1'b1;
        m2r     = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        mwr = 1'b1;
        iod = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_RTEXEC: begin
        asa     = 1'b1;
        aop     = 4'd2;
        state_d = S_RTWB;
      end
      S_RTWB: begin
        rw      = 1'b1;
        rdst    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_IEXEC: begin
        asa = 1'b1;
        asb = 2'b10;
        case (opcode)
          OP_ADDI: aop = 4'd3;
          OP_SLTI: aop = 4'd4;
          OP_ANDI: aop = 4'd5;
          OP_ORI:  aop = 4'd6;
          OP_LUI:  aop = 4'd7;
          default: aop = 4'd0;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        rw      = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        asa     = 1'b1;
        aop     = 4'd1;
        pcwc    = 1'b1;
        pcs     = 2'b01;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        pcw     = 1'b1;
        pcs     = 2'b10;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
`endif
      // Unused encodings (and JUMP when the feature is off) recover to FETCH.
      default: state_d = S_FETCH;
    endcase

    retired_d = retire ? retired_q + 16'd1 : retired_q;
  end

  // Reset is synchronous, so state_q may still hold a mid-instruction state in
  // the reset cycle; gate every side-effecting output so the instruction is
  // aborted without touching registers, memory or the PC.
  always_comb begin
    pc_write      = pcw  & ~reset;
    pc_write_cond = pcwc & ~reset;
    i_or_d        = iod;
    mem_read      = mrd  & ~reset;
    mem_write     = mwr  & ~reset;
    ir_write      = irw  & ~reset;
    mem_to_reg    = m2r;
    reg_dst       = rdst;
    reg_write     = rw   & ~reset;
    alu_src_a     = asa;
    alu_src_b     = asb;
    pc_source     = pcs;
    alu_op        = aop;
    illegal       = ill  & ~reset;
    state         = reset ? S_FETCH : state_q;
    retired       = reset ? 16'd0 : retired_q;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and randomized checks of multicycle_control
// against an instruction-level reference model (expected state trace per opcode
// and a per-state control table), checked every cycle.
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_source;
  logic [3:0]  alu_op, state;
  logic        illegal;
  logic [15:0] retired;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] rt    = 16'd0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state(state), .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {pcw,pcwc,iod,mrd,mwr,irw,m2r,rdst,rw,asa, asb[1:0], pcs[1:0], aop[3:0]}
  wire [17:0] ctrl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                          alu_src_b, pc_source, alu_op};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit jump_enabled();
`ifdef MULTICYCLE_JUMP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected controls for a state, straight from the per-state output list.
  function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] op, input bit mr);
    logic pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [3:0] aop;
    {pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'd0; pcs = 2'd0; aop = 4'd0;
    case (st)
      0:  begin mrd = 1; asb = 2'd1; pcw = mr; irw = mr; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin asa = 1; aop = 4'd2; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin
            asa = 1; asb = 2'd2;
            if (op == 6'h08) aop = 4'd3;
            else if (op == 6'h0A) aop = 4'd4;
            else if (op == 6'h0C) aop = 4'd5;
            else if (op == 6'h0D) aop = 4'd6;
            else if (op == 6'h0F) aop = 4'd7;
          end
      9:  rw = 1;
      10: begin asa = 1; aop = 4'd1; pcwc = 1; pcs = 2'd1; end
      11: begin pcw = 1; pcs = 2'd2; end
      default: ;
    endcase
    return {pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, pcs, aop};
  endfunction

  // Runs one instruction: wf fetch stalls, wm memory stalls. If abort_at>=0,
  // reset is asserted in that cycle of the instruction instead.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int abort_at);
    int st_q[$];
    bit mr_q[$];
    bit ill;
    ill = 1'b0;
    for (int i = 0; i < wf; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom_range(0, 1)));
    if (op == 6'h23 || op == 6'h2B) begin
      st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < wm; i++) begin
        st_q.push_back(op == 6'h23 ? 3 : 5); mr_q.push_back(1'b0);
      end
      st_q.push_back(op == 6'h23 ? 3 : 5); mr_q.push_back(1'b1);
      if (op == 6'h23) begin st_q.push_back(4); mr_q.push_back(1'($urandom_range(0, 1))); end
    end else if (op == 6'h00) begin
      st_q.push_back(6); mr_q.push_back(1'($urandom_range(0, 1)));
      st_q.push_back(7); mr_q.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D || op == 6'h0F) begin
      st_q.push_back(8); mr_q.push_back(1'($urandom_range(0, 1)));
      st_q.push_back(9); mr_q.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'h04) begin
      st_q.push_back(10); mr_q.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'h02 && jump_enabled()) begin
      st_q.push_back(11); mr_q.push_back(1'($urandom_range(0, 1)));
    end else begin
      ill = 1'b1;
    end

    for (int i = 0; i < st_q.size(); i++) begin
      @(posedge clk); #1;
      opcode    = op;
      mem_ready = mr_q[i];
      if (i == abort_at) begin
        reset = 1'b1;
        #2;
        check($sformatf("abort_state op=%0h", op), 32'(state), 32'd0);
        check($sformatf("abort_mem_write op=%0h", op), 32'(mem_write), 32'd0);
        check($sformatf("abort_reg_write op=%0h", op), 32'(reg_write), 32'd0);
        check($sformatf("abort_retired op=%0h", op), 32'(retired), 32'd0);
        check($sformatf("abort_illegal op=%0h", op), 32'(illegal), 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        #2;
        rt = 16'd0;
        check("post_abort_state", 32'(state), 32'd0);
        check("post_abort_retired", 32'(retired), 32'(rt));
        check("post_abort_mem_read", 32'(mem_read), 32'd1);
        return;
      end
      #2;
      check($sformatf("state op=%0h step=%0d", op, i), 32'(state), 32'(st_q[i]));
      check($sformatf("ctrl op=%0h step=%0d", op, i), 32'(ctrl_obs),
            32'(exp_ctrl(st_q[i], op, mr_q[i])));
      check($sformatf("illegal op=%0h step=%0d", op, i), 32'(illegal),
            32'(ill && st_q[i] == 1));
      check($sformatf("retired op=%0h step=%0d", op, i), 32'(retired), 32'(rt));
      check($sformatf("rw_mutex op=%0h step=%0d", op, i), 32'(mem_read & mem_write), 32'd0);
      if (i == st_q.size() - 1 && !ill) rt = rt + 16'd1;
    end
  endtask

  logic [5:0] pool [10];

  initial begin
    reset     = 1'b1;
    opcode    = 6'h00;
    mem_ready = 1'b0;

    // Reset: FETCH would drive mem_read/pc_write/ir_write, reset must mask them.
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #2;
    check("reset_state", 32'(state), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    check("reset_ctrl_writes", 32'({mem_read, mem_write, ir_write, pc_write,
                                    pc_write_cond, reg_write}), 32'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    mem_ready = 1'b0;
    #2;
    check("release_state", 32'(state), 32'd0);
    check("release_mem_read", 32'(mem_read), 32'd1);

    // Directed instructions.
    run_instr(6'h00, 0, 0, -1);   // R-type: 0,1,6,7
    run_instr(6'h23, 0, 3, -1);   // lw with 3 memory stalls
    run_instr(6'h0D, 1, 0, -1);   // ori with one fetch stall
    run_instr(6'h04, 0, 0, -1);   // beq
    run_instr(6'h3F, 0, 0, -1);   // illegal
    run_instr(6'h2B, 0, 2, 3);    // sw, reset in first MEMWR cycle
    run_instr(6'h02, 0, 0, -1);   // j (or illegal without the feature)
    run_instr(6'h2B, 0, 1, -1);   // sw completes normally

    // Randomized instruction mix.
    pool[0] = 6'h00; pool[1] = 6'h23; pool[2] = 6'h2B; pool[3] = 6'h08;
    pool[4] = 6'h0A; pool[5] = 6'h0C; pool[6] = 6'h0D; pool[7] = 6'h0F;
    pool[8] = 6'h04; pool[9] = 6'h02;
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = pool[$urandom_range(0, 9)];
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
    end

    // Last instruction must have returned to FETCH and retired.
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #2;
    check("final_state", 32'(state), 32'd0);
    check("final_retired", 32'(retired), 32'(rt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
